keypad_encoder_sync: RTL and testbench

KEYPAD_ENCODER_SYNC -- requirements
Module: keypad_encoder_sync

---
 rtl/keypad_pkg.sv | 14 +
 rtl/keypad_sync2.sv | 23 ++
 rtl/keypad_encoder_sync.sv | 121 ++++++++++++
 tb/tb_keypad_encoder_sync.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and default constants for the keypad encoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } kp_state_e;

  localparam int NUM_KEYS_DEF = 10;
  localparam int CODE_W_DEF   = 4;
  localparam int DEBOUNCE_DEF = 4;

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for asynchronous key lines.
module keypad_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder_sync.sv
// Debounced keypad encoder; KEYPAD_ENCODER_MULTI_ERR_EN rejects
// multi-key patterns with a multi_key pulse.
module keypad_encoder_sync
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEF,
  parameter int CODE_W          = CODE_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keyboard,
  input  logic                enablen,
  output logic [CODE_W-1:0]   bcd,
  output logic                valid_data,
  output logic                key_held,
  output logic                multi_key
);

  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

  kp_state_e           state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic [NUM_KEYS-1:0] kb_s, cand, cand_n;
  logic [CODE_W-1:0]   bcd_n, enc;
  logic                valid_n, multi_n;
  logic                legal, illegal, mlock;

  keypad_sync2 #(.W(NUM_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (keyboard),
    .q     (kb_s)
  );

`ifdef KEYPAD_ENCODER_MULTI_ERR_EN
  assign legal   = $onehot(kb_s);
  assign illegal = (|kb_s) && !legal;

  // Lock stops repeated error pulses until all keys are released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlock <= 1'b0;
    end else if (kb_s == '0) begin
      mlock <= 1'b0;
    end else if (multi_n) begin
      mlock <= 1'b1;
    end
  end
`else
  assign legal   = |kb_s;
  assign illegal = 1'b0;
  assign mlock   = 1'b1;
`endif

  // Highest set index wins.
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (cand[i]) enc = CODE_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    bcd_n   = bcd;
    valid_n = 1'b0;
    multi_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (!enablen && legal) begin
          cand_n  = kb_s;
          cnt_n   = 8'd1;
          state_n = DEBOUNCE;
        end else if (!enablen && illegal && !mlock) begin
          multi_n = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (enablen || kb_s != cand) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt < DB) begin
          cnt_n = cnt + 8'd1;
        end else begin
          bcd_n   = enc;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = HELD;
        end
      end
      HELD: begin
        if (kb_s == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      bcd        <= '0;
      valid_data <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cand       <= cand_n;
      bcd        <= bcd_n;
      valid_data <= valid_n;
      multi_key  <= multi_n;
    end
  end

  assign key_held = (state == HELD);

endmodule

// File: tb/tb_keypad_encoder_sync.sv
// Self-checking bench: two encoder instances against a press-level model.
module tb_keypad_encoder_sync;

  localparam int NK0 = 10;
  localparam int D0  = 4;
  localparam int NK1 = 16;
  localparam int D1  = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NK0-1:0] kb0;
  logic [NK1-1:0] kb1;
  logic           en0n, en1n;
  logic [3:0]     bcd0, bcd1;
  logic           v0, h0, m0, v1, h1, m1;

  keypad_encoder_sync #(
    .NUM_KEYS(NK0), .CODE_W(4), .DEBOUNCE_CYCLES(D0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .keyboard(kb0),
    .enablen(en0n), .bcd(bcd0), .valid_data(v0),
    .key_held(h0), .multi_key(m0)
  );

  keypad_encoder_sync #(
    .NUM_KEYS(NK1), .CODE_W(4), .DEBOUNCE_CYCLES(D1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .keyboard(kb1),
    .enablen(en1n), .bcd(bcd1), .valid_data(v1),
    .key_held(h1), .multi_key(m1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Press-level model: sync delay line, run length, held flag.
  logic [63:0] p1 [2];
  logic [63:0] p2 [2];
  logic [63:0] cand [2];
  int  run [2];
  bit  held [2];
  bit  lock [2];
  int  ebcd [2];
  bit  ev [2];
  bit  em [2];

  int ov [2];
  int om [2];
  int fv [2];
  int t0;

  function automatic bit multi_err_en();
`ifdef KEYPAD_ENCODER_MULTI_ERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_legal(logic [63:0] k);
    if (multi_err_en()) return $countones(k) == 1;
    return k != 0;
  endfunction

  function automatic int top_idx(logic [63:0] k);
    int r = 0;
    for (int i = 0; i < 64; i++) if (k[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      p1[i] = 0; p2[i] = 0; cand[i] = 0;
      run[i] = 0; held[i] = 0; lock[i] = 0;
      ebcd[i] = 0; ev[i] = 0; em[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [63:0] kin,
                            input bit en_n, input int d);
    logic [63:0] k;
    bit old_lock;
    k = p2[i];
    old_lock = lock[i];
    ev[i] = 0;
    em[i] = 0;
    if (held[i]) begin
      if (k == 0) held[i] = 0;
    end else if (run[i] > 0) begin
      if (en_n || k != cand[i]) run[i] = 0;
      else if (run[i] < d) run[i]++;
      else begin
        ebcd[i] = top_idx(cand[i]);
        ev[i] = 1; held[i] = 1; run[i] = 0;
      end
    end else if (!en_n && is_legal(k)) begin
      cand[i] = k;
      run[i] = 1;
    end else if (!en_n && k != 0 && !old_lock) begin
      em[i] = multi_err_en();
    end
    if (k == 0) lock[i] = 0;
    else if (em[i]) lock[i] = 1;
    p2[i] = p1[i];
    p1[i] = kin;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 2; i++) begin
      ov[i] = 0; om[i] = 0; fv[i] = -1;
    end
    t0 = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0, 64'(kb0), en0n, D0);
      model_step(1, 64'(kb1), en1n, D1);
    end
    cyc++;
    #1;
    chk("bcd0", 64'(bcd0), 64'(ebcd[0]));
    chk("valid0", 64'(v0), 64'(ev[0]));
    chk("held0", 64'(h0), 64'(held[0]));
    chk("multi0", 64'(m0), 64'(em[0]));
    chk("bcd1", 64'(bcd1), 64'(ebcd[1]));
    chk("valid1", 64'(v1), 64'(ev[1]));
    chk("held1", 64'(h1), 64'(held[1]));
    chk("multi1", 64'(m1), 64'(em[1]));
    if (v0 === 1'b1) begin ov[0]++; if (fv[0] < 0) fv[0] = cyc; end
    if (v1 === 1'b1) begin ov[1]++; if (fv[1] < 0) fv[1] = cyc; end
    if (m0 === 1'b1) om[0]++;
    if (m1 === 1'b1) om[1]++;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_bcd"}, 64'(bcd0), 64'd0);
    chk({tag, "_valid"}, 64'(v0), 64'd0);
    chk({tag, "_held"}, 64'(h0), 64'd0);
    chk({tag, "_multi"}, 64'(m0), 64'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    kb0 = '0; kb1 = '0;
    en0n = 1'b1; en1n = 1'b1;
    model_reset();
    ticks(3);
    chk("rst_bcd", 64'(bcd0), 64'd0);
    chk("rst_held", 64'(h0), 64'd0);
    rst_n = 1'b1;
    ticks(2);

    // Short press of key 3: no accept, bcd stays 0.
    en0n = 1'b0;
    clr_obs();
    kb0 = NK0'(1) << 3;
    ticks(3);
    kb0 = '0;
    ticks(8);
    chk("short_valid", 64'(ov[0]), 64'd0);
    chk("short_bcd", 64'(bcd0), 64'd0);

    // Key 7 held 20 cycles.
    clr_obs();
    kb0 = NK0'(1) << 7;
    ticks(20);
    kb0 = '0;
    ticks(6);
    chk("k7_count", 64'(ov[0]), 64'd1);
    chk("k7_lat", 64'(fv[0] - t0), 64'(3 + D0));
    chk("k7_bcd", 64'(bcd0), 64'd7);

    // Key 5 with scan disabled, then enabled while held.
    clr_obs();
    en0n = 1'b1;
    kb0 = NK0'(1) << 5;
    ticks(10);
    chk("dis_valid", 64'(ov[0]), 64'd0);
    en0n = 1'b0;
    ticks(10);
    chk("en_count", 64'(ov[0]), 64'd1);
    chk("en_bcd", 64'(bcd0), 64'd5);
    kb0 = '0;
    ticks(6);

    // Keys 2 and 9 together.
    clr_obs();
    kb0 = (NK0'(1) << 2) | (NK0'(1) << 9);
    ticks(15);
    kb0 = '0;
    ticks(6);
    if (multi_err_en()) begin
      chk("mk_multi", 64'(om[0]), 64'd1);
      chk("mk_valid", 64'(ov[0]), 64'd0);
    end else begin
      chk("mk_valid", 64'(ov[0]), 64'd1);
      chk("mk_bcd", 64'(bcd0), 64'd9);
    end

    // Reset mid-debounce, then mid-held, with key 4 kept down.
    kb0 = NK0'(1) << 4;
    ticks(4);
    pulse_reset("rst_deb");
    clr_obs();
    ticks(12);
    chk("rd_count", 64'(ov[0]), 64'd1);
    chk("rd_lat", 64'(fv[0] - t0), 64'(3 + D0));
    chk("rd_bcd", 64'(bcd0), 64'd4);
    pulse_reset("rst_held");
    clr_obs();
    ticks(12);
    chk("rh_count", 64'(ov[0]), 64'd1);
    chk("rh_bcd", 64'(bcd0), 64'd4);
    kb0 = '0;
    ticks(6);

    // Sixteen keys, single-sample debounce, key 15.
    clr_obs();
    en1n = 1'b0;
    kb1 = NK1'(1) << 15;
    ticks(8);
    chk("k15_count", 64'(ov[1]), 64'd1);
    chk("k15_lat", 64'(fv[1] - t0), 64'(3 + D1));
    chk("k15_bcd", 64'(bcd1), 64'd15);
    kb1 = '0;
    ticks(4);

    // Random presses on both instances.
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        kb0 = '0; kb1 = '0;
      end else if (sel < 8) begin
        kb0 = NK0'(1) << $urandom_range(0, NK0 - 1);
        kb1 = NK1'(1) << $urandom_range(0, NK1 - 1);
      end else begin
        kb0 = NK0'($urandom);
        kb1 = NK1'($urandom);
      end
      en0n = ($urandom_range(0, 4) == 0);
      en1n = ($urandom_range(0, 4) == 0);
      ticks($urandom_range(1, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
